// File: rtl/parking_timer_scheduler.sv
// Shared prescaled timebase driving NUM_CH independent countdown timers.
// The tick is a clock enable on clk_in; no derived clock is produced.
`timescale 1ns/1ps

module parking_timer_scheduler #(
    parameter int CLK_FREQ = 40000000,
    parameter int TICK_HZ  = 1,
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic                    div_load,
    input  logic [31:0]             div_val,
    output logic                    tick_out,
    input  logic [NUM_CH-1:0]       ch_start,
    input  logic [NUM_CH-1:0]       ch_cancel,
    input  logic [NUM_CH*CNT_W-1:0] ch_duration,
    output logic [NUM_CH-1:0]       ch_busy,
    output logic [NUM_CH-1:0]       ch_done,
    input  logic [2:0]              rd_sel,
    output logic [CNT_W-1:0]        rd_remaining
);

    localparam logic [31:0] DIV_RAW = 32'(CLK_FREQ / TICK_HZ);
    localparam logic [31:0] DIV_RST = (DIV_RAW < 32'd2) ? 32'd2 : DIV_RAW;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    logic [31:0]      div_q, div_d;
    logic [31:0]      cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             wrap;

    ch_state_e        state_q [NUM_CH];
    ch_state_e        state_d [NUM_CH];
    logic [CNT_W-1:0] rem_q   [NUM_CH];
    logic [CNT_W-1:0] rem_d   [NUM_CH];
    logic [CNT_W-1:0] dur     [NUM_CH];
    logic [NUM_CH-1:0] done_q, done_d;
    logic [CNT_W-1:0] rd_q, rd_d;

    // ------------------------------------------------------------------
    // Prescaler: wrap is the internal tick, tick_out is its registered copy
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        div_d = div_q;
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (div_load) begin
            // A wrap that would fall in this cycle is deliberately dropped.
            div_d = (div_val < 32'd2) ? 32'd2 : div_val;
            cnt_d = '0;
        end else if (cnt_q >= div_q - 32'd1) begin
            wrap  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
        tick_d = wrap;
    end

    // ------------------------------------------------------------------
    // Channel FSMs: cancel > start > tick; a start swallows a same-cycle tick
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            dur[i] = ch_duration[i*CNT_W +: CNT_W];
        end
    end

    always_comb begin
        done_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            rem_d[i]   = rem_q[i];
            if (ch_cancel[i]) begin
                state_d[i] = CH_IDLE;
                rem_d[i]   = '0;
            end else if (ch_start[i]) begin
                if (dur[i] != '0) begin
                    state_d[i] = CH_RUN;
                    rem_d[i]   = dur[i];
                end else begin
                    state_d[i] = CH_IDLE;
                    rem_d[i]   = '0;
                    done_d[i]  = 1'b1;
                end
            end else if (state_q[i] == CH_RUN && wrap) begin
                if (rem_q[i] > CNT_W'(1)) begin
                    rem_d[i] = rem_q[i] - CNT_W'(1);
                end else begin
                    state_d[i] = CH_IDLE;
                    rem_d[i]   = '0;
                    done_d[i]  = 1'b1;
                end
            end
        end
    end

    // Unpopulated selects never match, so they read back as zero.
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == 3'(i)) begin
                rd_d = rem_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            div_q  <= DIV_RST;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            done_q <= '0;
            rd_q   <= '0;
            // NOTE: the per-channel arrays are small control state, not a
            // RAM, so they are reset element by element.
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= CH_IDLE;
                rem_q[i]   <= '0;
            end
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            done_q <= done_d;
            rd_q   <= rd_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                rem_q[i]   <= rem_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_busy[i] = (state_q[i] == CH_RUN);
        end
    end

    assign tick_out     = tick_q;
    assign ch_done      = done_q;
    assign rd_remaining = rd_q;

endmodule
